// File: rtl/jtdd_mbox_pkg.sv
// Shared types and constants for the main/sub CPU mailbox.
package jtdd_mbox_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_GRANT = 2'd2
   } halt_st_t;

   localparam int LATW    = 8;
   localparam int NCH_MAX = 4;

   // Strobe qualifier shared by RAM and latch write paths.
   function automatic logic wr_strobe(input logic cen, input logic sel, input logic wrn);
      return cen & sel & ~wrn;
   endfunction

endpackage

// File: rtl/jtdd_mbox_if.sv
// Mailbox bus bundle: main CPU side, sub CPU side and the halt/interrupt handshakes.
interface jtdd_mbox_if #(
   parameter int AW  = 9,
   parameter int NCH = 2
);
   import jtdd_mbox_pkg::*;

   logic                  main_cen;
   logic [AW-1:0]         main_AB;
   logic                  main_wrn;
   logic [LATW-1:0]       main_dout;
   logic                  com_cs;
   logic [NCH-1:0]        lat_cs;
   logic [LATW-1:0]       main_din;
   logic                  main_ban;
   logic                  halt_req;
   logic                  sub_halt;
   logic                  sub_ba;
   logic                  nmi_set;
   logic                  sub_nmi;
   logic                  sub_nmi_ack;
   logic                  irqmain_set;
   logic                  main_irq;
   logic                  main_irq_ack;
   logic                  sub_cen;
   logic [AW-1:0]         sub_AB;
   logic                  sub_we;
   logic [LATW-1:0]       sub_dout;
   logic [LATW-1:0]       sub_din;
   logic [NCH-1:0]        sub_lat_rd;
   logic [LATW*NCH-1:0]   sub_latch;
   logic [NCH-1:0]        sub_irq;
   logic [NCH-1:0]        lat_ovr;

   modport master (
      output main_cen, main_AB, main_wrn, main_dout, com_cs, lat_cs,
      output halt_req, sub_ba, nmi_set, sub_nmi_ack, irqmain_set, main_irq_ack,
      output sub_cen, sub_AB, sub_we, sub_dout, sub_lat_rd,
      input  main_din, main_ban, sub_halt, sub_nmi, main_irq,
      input  sub_din, sub_latch, sub_irq, lat_ovr
   );

   modport slave (
      input  main_cen, main_AB, main_wrn, main_dout, com_cs, lat_cs,
      input  halt_req, sub_ba, nmi_set, sub_nmi_ack, irqmain_set, main_irq_ack,
      input  sub_cen, sub_AB, sub_we, sub_dout, sub_lat_rd,
      output main_din, main_ban, sub_halt, sub_nmi, main_irq,
      output sub_din, sub_latch, sub_irq, lat_ovr
   );

endinterface

// File: rtl/jtframe_dual_ram.sv
// Two-port byte RAM on one clock; registered reads (1 clk), read-before-write per port.
// Read registers clear on rst; array contents are never cleared.
module jtframe_dual_ram #(
   parameter int DW = 8,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] data0,
   input  logic [AW-1:0] addr0,
   input  logic          we0,
   output logic [DW-1:0] q0,
   input  logic [DW-1:0] data1,
   input  logic [AW-1:0] addr1,
   input  logic          we1,
   output logic [DW-1:0] q1
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we0) mem[addr0] <= data0;
      if (we1) mem[addr1] <= data1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q0 <= '0;
         q1 <= '0;
      end else begin
         q0 <= mem[addr0];
         q1 <= mem[addr1];
      end
   end

endmodule

// File: rtl/jtdd_mbox.sv
// Main/sub CPU mailbox: shared RAM, NCH byte latches with pending IRQs, NMI/IRQ pair, halt handshake.
// Optional overrun flags under JTDD_MBOX_OVR_EN; main RAM access waits (main_ban) until the sub bus is granted.
module jtdd_mbox
   import jtdd_mbox_pkg::*;
#(
   parameter int AW  = 9,
   parameter int NCH = 2
) (
   input  logic        clk,
   input  logic        rst,
   jtdd_mbox_if.slave  bus
);

   halt_st_t st, st_nxt;
   logic     halt_o, ban_o, sub_ok;
   logic     main_we, sub_we_q;
   logic     nmi_q, irq_q;
   logic [NCH-1:0] pend_v, ovr_v;

   always_ff @(posedge clk) begin
      if (rst) st <= ST_IDLE;
      else     st <= st_nxt;
   end

   // A withdrawn request always wins, so REQ never grants without halt_req.
   always_comb begin
      st_nxt = st;
      case (st)
         ST_IDLE:  if (bus.halt_req) st_nxt = ST_REQ;
         ST_REQ: begin
            if (!bus.halt_req)   st_nxt = ST_IDLE;
            else if (bus.sub_ba) st_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            if (!bus.halt_req)    st_nxt = ST_IDLE;
            else if (!bus.sub_ba) st_nxt = ST_REQ;
         end
         default:  st_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      halt_o = (st != ST_IDLE);
      ban_o  = bus.com_cs & (st != ST_GRANT);
      sub_ok = (st == ST_IDLE);
   end

   assign bus.sub_halt = halt_o;
   assign bus.main_ban = ban_o;

   assign main_we  = wr_strobe(bus.main_cen, bus.com_cs, bus.main_wrn) & ~ban_o;
   assign sub_we_q = bus.sub_we & bus.sub_cen & sub_ok;

   jtframe_dual_ram #(.DW(LATW), .AW(AW)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .data0 (bus.main_dout),
      .addr0 (bus.main_AB),
      .we0   (main_we),
      .q0    (bus.main_din),
      .data1 (bus.sub_dout),
      .addr1 (bus.sub_AB),
      .we1   (sub_we_q),
      .q1    (bus.sub_din)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         nmi_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (bus.nmi_set)          nmi_q <= 1'b1;
         else if (bus.sub_nmi_ack) nmi_q <= 1'b0;
         if (bus.irqmain_set)       irq_q <= 1'b1;
         else if (bus.main_irq_ack) irq_q <= 1'b0;
      end
   end

   assign bus.sub_nmi  = nmi_q;
   assign bus.main_irq = irq_q;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic            wr, rd;
      logic [LATW-1:0] lat;
      logic            pend;

      assign wr = wr_strobe(bus.main_cen, bus.lat_cs[k], bus.main_wrn);
      assign rd = bus.sub_cen & bus.sub_lat_rd[k];

      // A fresh write takes priority over a coincident read so no byte is lost silently.
      always_ff @(posedge clk) begin
         if (rst) begin
            lat  <= '0;
            pend <= 1'b0;
         end else if (wr) begin
            lat  <= bus.main_dout;
            pend <= 1'b1;
         end else if (rd) begin
            pend <= 1'b0;
         end
      end

      assign bus.sub_latch[LATW*k +: LATW] = lat;
      assign pend_v[k] = pend;

`ifdef JTDD_MBOX_OVR_EN
      logic ovr;
      always_ff @(posedge clk) begin
         if (rst)            ovr <= 1'b0;
         else if (wr & pend) ovr <= 1'b1;
      end
      assign ovr_v[k] = ovr;
`else
      assign ovr_v[k] = 1'b0;
`endif
   end

   assign bus.sub_irq = pend_v;
   assign bus.lat_ovr = ovr_v;

endmodule
